// File: rtl/mcycle_ctrl_seq.sv
// mcycle_ctrl_seq: multicycle control sequencer for the MIPS-subset datapath.
// Drives PC, IR, A/B, ALUOut, register file, HI/LO and EPC load/select lines.
// Memory wait states and the MULT/DIV iteration count are parameters; illegal
// instructions and arithmetic overflow share one EPC-save / vector-load path.
// Optional build macro: CTRL_DIV_ZERO_TRAP_EN -- when defined, a div with a
// zero divisor traps with cause 11 instead of running the divider.
// Control outputs are registered from the next-state decode, so each output
// lines up with the state it belongs to; reset masks every output to 0.
module mcycle_ctrl_seq #(
   parameter int MEM_WAIT = 2,
   parameter int MD_ITER  = 32,
   parameter int CNT_W    = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       alu_overflow,
   input  logic       div_zero,
   output logic       pc_write,
   output logic [2:0] pc_source,
   output logic       ir_write,
   output logic [1:0] mem_add,
   output logic       alu_src_a,
   output logic [2:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic       reg_a_write,
   output logic       reg_b_write,
   output logic       alu_out_write,
   output logic       reg_write,
   output logic [2:0] reg_dest,
   output logic [3:0] reg_data,
   output logic       mult_op,
   output logic       div_op,
   output logic       hi_write,
   output logic       lo_write,
   output logic       mux_hilo,
   output logic       epc_write,
   output logic       busy_md,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_MEM_WAIT  = 4'd1,
      ST_IR_LOAD   = 4'd2,
      ST_DECODE    = 4'd3,
      ST_EXEC      = 4'd4,
      ST_WB        = 4'd5,
      ST_MD_RUN    = 4'd6,
      ST_MD_DONE   = 4'd7,
      ST_EXCP_SAVE = 4'd8,
      ST_EXCP_WAIT = 4'd9,
      ST_EXCP_LOAD = 4'd10
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_SLT  = 4'd3,
      OP_ADDI = 4'd4,
      OP_JR   = 4'd5,
      OP_J    = 4'd6,
      OP_MULT = 4'd7,
      OP_DIV  = 4'd8,
      OP_ILL  = 4'd9
   } op_t;

   typedef struct packed {
      logic       pc_write;
      logic [2:0] pc_source;
      logic       ir_write;
      logic [1:0] mem_add;
      logic       alu_src_a;
      logic [2:0] alu_src_b;
      logic [2:0] alu_control;
      logic       reg_a_write;
      logic       reg_b_write;
      logic       alu_out_write;
      logic       reg_write;
      logic [2:0] reg_dest;
      logic [3:0] reg_data;
      logic       mult_op;
      logic       div_op;
      logic       hi_write;
      logic       lo_write;
      logic       mux_hilo;
      logic       epc_write;
      logic       busy_md;
   } ctl_t;

   // exception causes double as the vector address select on mem_add
   localparam logic [1:0] CAUSE_ILL  = 2'b01;
   localparam logic [1:0] CAUSE_OVF  = 2'b10;
   localparam logic [1:0] CAUSE_DIV0 = 2'b11;

   localparam logic [CNT_W-1:0] MEM_WAIT_C = CNT_W'(MEM_WAIT);
   localparam logic [CNT_W-1:0] MD_ITER_C  = CNT_W'(MD_ITER);
   localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);

   // instruction class from opcode/funct; anything unrecognised is illegal
   function automatic op_t classify(input logic [5:0] op, input logic [5:0] fn);
      op_t k;
      k = OP_ILL;
      case (op)
         6'h00: begin
            case (fn)
               6'h20:   k = OP_ADD;
               6'h22:   k = OP_SUB;
               6'h24:   k = OP_AND;
               6'h2A:   k = OP_SLT;
               6'h18:   k = OP_MULT;
               6'h1A:   k = OP_DIV;
               6'h08:   k = OP_JR;
               default: k = OP_ILL;
            endcase
         end
         6'h08:   k = OP_ADDI;
         6'h02:   k = OP_J;
         default: k = OP_ILL;
      endcase
      return k;
   endfunction

   // control word for a given state; unlisted fields stay 0
   function automatic ctl_t decode_ctl(input state_t st, input logic kind,
                                       input logic [1:0] cause, input op_t k);
      ctl_t c;
      c = '0;
      case (st)
         ST_FETCH: begin
            c.pc_write    = 1'b1;
            c.pc_source   = 3'b001;
            c.mem_add     = 2'b00;
            c.alu_src_a   = 1'b0;
            c.alu_src_b   = 3'b011;
            c.alu_control = 3'b001;
         end
         ST_MEM_WAIT: c.mem_add = 2'b00;
         ST_IR_LOAD:  c.ir_write = 1'b1;
         ST_DECODE: begin
            c.reg_a_write   = 1'b1;
            c.reg_b_write   = 1'b1;
            c.alu_out_write = 1'b1;
            c.alu_src_b     = 3'b100;
            c.alu_control   = 3'b001;
         end
         ST_EXEC: begin
            case (k)
               OP_ADD, OP_SUB, OP_AND, OP_SLT: begin
                  c.alu_src_a     = 1'b1;
                  c.alu_src_b     = 3'b000;
                  c.alu_out_write = 1'b1;
                  case (k)
                     OP_SUB:  c.alu_control = 3'b010;
                     OP_AND:  c.alu_control = 3'b011;
                     OP_SLT:  c.alu_control = 3'b111;
                     default: c.alu_control = 3'b001;
                  endcase
               end
               OP_ADDI: begin
                  c.alu_src_a     = 1'b1;
                  c.alu_src_b     = 3'b010;
                  c.alu_control   = 3'b001;
                  c.alu_out_write = 1'b1;
               end
               OP_JR: begin
                  c.pc_write    = 1'b1;
                  c.pc_source   = 3'b001;
                  c.alu_src_a   = 1'b1;
                  c.alu_control = 3'b000;
               end
               OP_J: begin
                  c.pc_write  = 1'b1;
                  c.pc_source = 3'b000;
               end
               default: c.pc_write = 1'b0;
            endcase
         end
         ST_WB: begin
            c.reg_write = 1'b1;
            c.reg_dest  = (k == OP_ADDI) ? 3'b000 : 3'b001;
            c.reg_data  = (k == OP_SLT) ? 4'b0010 : 4'b0000;
         end
         ST_MD_RUN: begin
            c.busy_md = 1'b1;
            c.mult_op = ~kind;
            c.div_op  = kind;
         end
         ST_MD_DONE: begin
            c.busy_md  = 1'b1;
            c.hi_write = 1'b1;
            c.lo_write = 1'b1;
            c.mux_hilo = kind;
         end
         ST_EXCP_SAVE: begin
            c.epc_write   = 1'b1;
            c.alu_src_a   = 1'b0;
            c.alu_src_b   = 3'b011;
            c.alu_control = 3'b010;
            c.mem_add     = cause;
         end
         ST_EXCP_WAIT: c.mem_add = cause;
         ST_EXCP_LOAD: begin
            c.pc_write  = 1'b1;
            c.pc_source = 3'b011;
            c.mem_add   = cause;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             kind_r;      // 0 mult, 1 div
   logic [1:0]       cause_r;
   ctl_t             ctl_r;

   state_t           nx_state_s;
   logic [CNT_W-1:0] nx_cnt_s;
   logic             nx_kind_s;
   logic [1:0]       nx_cause_s;
   op_t              op_k_s;
   ctl_t             ctl_o_s;

`ifndef CTRL_DIV_ZERO_TRAP_EN
   // without the trap the divisor-zero flag has no effect on sequencing
   logic unused_div_zero_s;
   assign unused_div_zero_s = div_zero;
`endif

   // next-state, counter, latched op kind and latched cause
   always_comb begin
      nx_state_s = state_r;
      nx_cnt_s   = cnt_r;
      nx_kind_s  = kind_r;
      nx_cause_s = cause_r;
      op_k_s     = classify(opcode, funct);
      case (state_r)
         ST_FETCH: begin
            if (MEM_WAIT == 0) begin
               nx_state_s = ST_IR_LOAD;
            end else begin
               nx_state_s = ST_MEM_WAIT;
               nx_cnt_s   = MEM_WAIT_C;
            end
         end
         ST_MEM_WAIT: begin
            if (cnt_r <= CNT_ONE_C) begin
               nx_state_s = ST_IR_LOAD;
               nx_cnt_s   = CNT_ZERO_C;
            end else begin
               nx_cnt_s   = cnt_r - CNT_ONE_C;
            end
         end
         ST_IR_LOAD: nx_state_s = ST_DECODE;
         ST_DECODE:  nx_state_s = ST_EXEC;
         ST_EXEC: begin
            case (op_k_s)
               OP_ADD, OP_SUB, OP_ADDI: begin
                  if (alu_overflow) begin
                     nx_state_s = ST_EXCP_SAVE;
                     nx_cause_s = CAUSE_OVF;
                  end else begin
                     nx_state_s = ST_WB;
                  end
               end
               OP_AND, OP_SLT: nx_state_s = ST_WB;
               OP_JR, OP_J:    nx_state_s = ST_FETCH;
               OP_MULT, OP_DIV: begin
                  nx_kind_s = (op_k_s == OP_DIV);
                  if (MD_ITER == 0) begin
                     nx_state_s = ST_MD_DONE;
                     nx_cnt_s   = CNT_ZERO_C;
                  end else begin
                     nx_state_s = ST_MD_RUN;
                     nx_cnt_s   = MD_ITER_C;
                  end
`ifdef CTRL_DIV_ZERO_TRAP_EN
                  if ((op_k_s == OP_DIV) && div_zero) begin
                     nx_state_s = ST_EXCP_SAVE;
                     nx_cause_s = CAUSE_DIV0;
                     nx_cnt_s   = CNT_ZERO_C;
                  end else begin
                     nx_cause_s = cause_r;
                  end
`endif
               end
               default: begin
                  nx_state_s = ST_EXCP_SAVE;
                  nx_cause_s = CAUSE_ILL;
               end
            endcase
         end
         ST_WB: nx_state_s = ST_FETCH;
         ST_MD_RUN: begin
            if (cnt_r <= CNT_ONE_C) begin
               nx_state_s = ST_MD_DONE;
               nx_cnt_s   = CNT_ZERO_C;
            end else begin
               nx_cnt_s   = cnt_r - CNT_ONE_C;
            end
         end
         ST_MD_DONE: nx_state_s = ST_FETCH;
         ST_EXCP_SAVE: begin
            if (MEM_WAIT == 0) begin
               nx_state_s = ST_EXCP_LOAD;
            end else begin
               nx_state_s = ST_EXCP_WAIT;
               nx_cnt_s   = MEM_WAIT_C;
            end
         end
         ST_EXCP_WAIT: begin
            if (cnt_r <= CNT_ONE_C) begin
               nx_state_s = ST_EXCP_LOAD;
               nx_cnt_s   = CNT_ZERO_C;
            end else begin
               nx_cnt_s   = cnt_r - CNT_ONE_C;
            end
         end
         ST_EXCP_LOAD: nx_state_s = ST_FETCH;
         default:      nx_state_s = ST_FETCH;
      endcase
   end

   // sequencer registers and the control word for the state being entered
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_FETCH;
         cnt_r   <= CNT_ZERO_C;
         kind_r  <= 1'b0;
         cause_r <= 2'b00;
         ctl_r   <= decode_ctl(ST_FETCH, 1'b0, 2'b00, OP_ILL);
      end else begin
         state_r <= nx_state_s;
         cnt_r   <= nx_cnt_s;
         kind_r  <= nx_kind_s;
         cause_r <= nx_cause_s;
         ctl_r   <= decode_ctl(nx_state_s, nx_kind_s, nx_cause_s, op_k_s);
      end
   end

   // reset holds every output and the state readback at 0
   always_comb begin
      if (reset) begin
         ctl_o_s = '0;
         state   = 4'd0;
      end else begin
         ctl_o_s = ctl_r;
         state   = state_r;
      end
   end

   assign pc_write      = ctl_o_s.pc_write;
   assign pc_source     = ctl_o_s.pc_source;
   assign ir_write      = ctl_o_s.ir_write;
   assign mem_add       = ctl_o_s.mem_add;
   assign alu_src_a     = ctl_o_s.alu_src_a;
   assign alu_src_b     = ctl_o_s.alu_src_b;
   assign alu_control   = ctl_o_s.alu_control;
   assign reg_a_write   = ctl_o_s.reg_a_write;
   assign reg_b_write   = ctl_o_s.reg_b_write;
   assign alu_out_write = ctl_o_s.alu_out_write;
   assign reg_write     = ctl_o_s.reg_write;
   assign reg_dest      = ctl_o_s.reg_dest;
   assign reg_data      = ctl_o_s.reg_data;
   assign mult_op       = ctl_o_s.mult_op;
   assign div_op        = ctl_o_s.div_op;
   assign hi_write      = ctl_o_s.hi_write;
   assign lo_write      = ctl_o_s.lo_write;
   assign mux_hilo      = ctl_o_s.mux_hilo;
   assign epc_write     = ctl_o_s.epc_write;
   assign busy_md       = ctl_o_s.busy_md;

endmodule
